// File: rtl/wb_lsu_master.sv
// wb_lsu_master
// Wishbone classic single-transfer master for the core's load/store stage.
// It takes one byte/half/word request at a time, runs a single bus cycle,
// and returns the load data extracted from its byte lanes and extended.
// Misaligned or illegal-size requests complete without any bus activity.
// A bus cycle that gets no ACK_I within TIMEOUT_CYCLES is abandoned.
//
// Ports
//   CLK_I, RST_I        clock (rising edge), asynchronous active-high reset
//   req_*               core request: valid/ready handshake, we, size,
//                       unsigned, byte address, right-aligned store data
//   resp_*              one-cycle completion pulse with extended load data,
//                       misaligned and timeout flags
//   CYC_O .. SEL_O      registered Wishbone master outputs
//   ACK_I, DAT_I        slave acknowledge and read data
module wb_lsu_master #(
  parameter int ADDR_WIDTH      = 24,
  parameter int REGISTERED_READ = 1,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  resp_valid_o,
  output logic [31:0]           resp_rdata_o,
  output logic                  resp_misaligned_o,
  output logic                  resp_timeout_o,
  output logic                  CYC_O,
  output logic                  STB_O,
  output logic                  WE_O,
  output logic [ADDR_WIDTH-1:0] ADR_O,
  output logic [31:0]           DAT_O,
  output logic [3:0]            SEL_O,
  input  logic                  ACK_I,
  input  logic [31:0]           DAT_I
);

  typedef enum logic [1:0] {IDLE, BUS, CAPTURE, RESP} state_t;

  // The counter only has to reach TIMEOUT_CYCLES-1: the abort happens on the
  // edge that would have made it TIMEOUT_CYCLES.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;

  logic                  cyc_d, stb_d, we_d;
  logic [ADDR_WIDTH-1:0] adr_d;
  logic [31:0]           dat_d;
  logic [3:0]            sel_d;
  logic                  rvalid_d, rmis_d, rto_d;
  logic [31:0]           rdata_d;

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
    unique case (sz)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      2'b10:   return (a != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] sel_for(input logic [1:0] sz, input logic [1:0] a);
    unique case (sz)
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  // Slaves pick their lane out of DAT_O, so narrow stores are replicated.
  function automatic logic [31:0] wdata_lanes(input logic [1:0] sz, input logic [31:0] wd);
    unique case (sz)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [1:0] sz,
                                              input logic [1:0] a, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{a, 3'b000} +: 8];
    h = d[{a[1], 4'b0000} +: 16];
    unique case (sz)
      2'b00:   return {{24{~uns & b[7]}}, b};
      2'b01:   return {{16{~uns & h[15]}}, h};
      default: return d;
    endcase
  endfunction

  assign req_ready_o = (state_q == IDLE) && !RST_I;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    size_d   = size_q;
    uns_d    = uns_q;
    cyc_d    = CYC_O;
    stb_d    = STB_O;
    we_d     = WE_O;
    adr_d    = ADR_O;
    dat_d    = DAT_O;
    sel_d    = SEL_O;
    rvalid_d = resp_valid_o;
    rmis_d   = resp_misaligned_o;
    rto_d    = resp_timeout_o;
    rdata_d  = resp_rdata_o;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          size_d = req_size_i;
          uns_d  = req_unsigned_i;
          we_d   = req_we_i;
          adr_d  = req_addr_i;
          dat_d  = wdata_lanes(req_size_i, req_wdata_i);
          sel_d  = sel_for(req_size_i, req_addr_i[1:0]);
          if (is_misaligned(req_size_i, req_addr_i[1:0])) begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            rmis_d   = 1'b1;
            rdata_d  = '0;
          end else begin
            state_d = BUS;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      BUS: begin
        // ACK takes priority over a timeout expiring in the same cycle.
        if (ACK_I) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          if (WE_O || REGISTERED_READ == 0) begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            rdata_d  = WE_O ? 32'h0 : load_extend(DAT_I, size_q, ADR_O[1:0], uns_q);
          end else begin
            state_d = CAPTURE;
          end
        end else if (TIMEOUT_CYCLES > 0 && cnt_q == TO_LAST) begin
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          state_d  = RESP;
          rvalid_d = 1'b1;
          rto_d    = 1'b1;
          rdata_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CAPTURE: begin
        // Registered-read slaves present DAT_I during this bus-idle cycle.
        state_d  = RESP;
        rvalid_d = 1'b1;
        rdata_d  = load_extend(DAT_I, size_q, ADR_O[1:0], uns_q);
      end
      RESP: begin
        state_d  = IDLE;
        rvalid_d = 1'b0;
        rmis_d   = 1'b0;
        rto_d    = 1'b0;
        rdata_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- register stage: state and all bus/response outputs ----
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      size_q            <= '0;
      uns_q             <= 1'b0;
      CYC_O             <= 1'b0;
      STB_O             <= 1'b0;
      WE_O              <= 1'b0;
      ADR_O             <= '0;
      DAT_O             <= '0;
      SEL_O             <= '0;
      resp_valid_o      <= 1'b0;
      resp_misaligned_o <= 1'b0;
      resp_timeout_o    <= 1'b0;
      resp_rdata_o      <= '0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      size_q            <= size_d;
      uns_q             <= uns_d;
      CYC_O             <= cyc_d;
      STB_O             <= stb_d;
      WE_O              <= we_d;
      ADR_O             <= adr_d;
      DAT_O             <= dat_d;
      SEL_O             <= sel_d;
      resp_valid_o      <= rvalid_d;
      resp_misaligned_o <= rmis_d;
      resp_timeout_o    <= rto_d;
      resp_rdata_o      <= rdata_d;
    end
  end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Self-checking bench for wb_lsu_master (REGISTERED_READ=1, TIMEOUT_CYCLES=4).
// The slave acknowledges combinationally after a programmable number of wait
// states and presents read data only in the cycle after ACK_I; every other
// cycle DAT_I carries the inverted value so a mistimed capture shows up.
module tb_wb_lsu_master;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        req_valid_i, req_we_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [23:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        req_ready_o, resp_valid_o, resp_misaligned_o, resp_timeout_o;
  logic [31:0] resp_rdata_o;
  logic        CYC_O, STB_O, WE_O;
  logic [23:0] ADR_O;
  logic [31:0] DAT_O;
  logic [3:0]  SEL_O;
  logic        ACK_I;
  logic [31:0] DAT_I;

  int n_checks = 0;
  int n_fail   = 0;

  logic        ack_en    = 1'b1;
  logic        ack_force = 1'b0;
  int          ack_waits = 0;
  int          stb_ctr   = 0;
  logic        ack_prev  = 1'b0;
  logic [31:0] rd_val    = 32'h0;

  wb_lsu_master #(.ADDR_WIDTH(24), .REGISTERED_READ(1), .TIMEOUT_CYCLES(4)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .resp_misaligned_o(resp_misaligned_o), .resp_timeout_o(resp_timeout_o),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
    .SEL_O(SEL_O), .ACK_I(ACK_I), .DAT_I(DAT_I)
  );

  always #5 CLK_I = ~CLK_I;

  // Slave model
  assign ACK_I = ack_force | (STB_O & ack_en & (stb_ctr >= ack_waits));
  always @(posedge CLK_I) begin
    stb_ctr  <= (STB_O && !ACK_I) ? stb_ctr + 1 : 0;
    ack_prev <= ACK_I;
  end
  always @(negedge CLK_I) DAT_I = ack_prev ? rd_val : ~rd_val;

  // Reference model
  function automatic bit m_misaligned(input logic [1:0] sz, input logic [23:0] addr);
    if (sz == 2'd3) return 1'b1;
    return (int'(addr[1:0]) % (1 << sz)) != 0;
  endfunction

  function automatic logic [3:0] m_sel(input logic [1:0] sz, input logic [23:0] addr);
    int nb = 1 << sz;
    int s  = ((1 << nb) - 1) << int'(addr[1:0]);
    return s[3:0];
  endfunction

  function automatic logic [31:0] m_dat(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return {24'h0, wd[7:0]} * 32'h01010101;
    if (sz == 2'd1) return {16'h0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] sz, input logic uns,
                                          input logic [23:0] addr, input logic [31:0] d);
    longint v;
    int     sh, bits;
    if (sz == 2'd2) return d;
    bits = (sz == 2'd0) ? 8 : 16;
    sh   = (sz == 2'd0) ? 8 * int'(addr[1:0]) : 16 * int'(addr[1]);
    v    = (longint'(d) >> sh) & ((longint'(1) << bits) - 1);
    if (!uns && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return v[31:0];
  endfunction

  // Issues one request at the current negedge and follows it to completion.
  // Returns at the negedge of the cycle after the response pulse.
  task automatic run_txn(input string nm, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [23:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int waits, input bit ack_on);
    bit          mis, e_to, bus_ok;
    logic [3:0]  e_sel;
    logic [31:0] e_dat, e_rd, g_rd;
    logic        g_mis, g_to;
    int          e_lat, e_bus, resp_cyc, pulses, bus_cyc;
    mis   = m_misaligned(sz, addr);
    e_to  = !mis && !ack_on;
    e_bus = mis ? 0 : (e_to ? 4 : waits + 1);
    e_lat = mis ? 1 : (e_to ? 5 : (we ? waits + 2 : waits + 3));
    e_sel = m_sel(sz, addr);
    e_dat = m_dat(sz, wd);
    e_rd  = (mis || e_to || we) ? 32'h0 : m_rdata(sz, uns, addr, rd);
    g_rd = 32'h0; g_mis = 1'b0; g_to = 1'b0;
    resp_cyc = -1; pulses = 0; bus_cyc = 0; bus_ok = 1'b1;

    n_checks++;
    if (req_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_before: got %b want 1", nm, req_ready_o);
    end
    ack_en = ack_on; ack_waits = waits; rd_val = rd;
    req_valid_i = 1'b1; req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wd;
    @(posedge CLK_I);
    #1;
    req_valid_i = 1'b0; req_we_i = $urandom; req_size_i = 2'($urandom);
    req_unsigned_i = $urandom; req_addr_i = 24'($urandom); req_wdata_i = $urandom;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK_I);
      if (CYC_O === 1'b1) begin
        bus_cyc++;
        if (STB_O !== 1'b1 || WE_O !== we || ADR_O !== addr || SEL_O !== e_sel ||
            (we && DAT_O !== e_dat)) bus_ok = 1'b0;
      end else if (STB_O !== 1'b0) bus_ok = 1'b0;
      if (resp_valid_o === 1'b1) begin
        pulses++;
        if (resp_cyc < 0) begin
          resp_cyc = c; g_rd = resp_rdata_o; g_mis = resp_misaligned_o; g_to = resp_timeout_o;
        end
      end
      if (resp_cyc >= 0 && c == resp_cyc + 1) break;
    end

    n_checks++;
    if (resp_cyc != e_lat) begin
      n_fail++; $display("FAIL %s latency: got %0d want %0d", nm, resp_cyc, e_lat);
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL %s resp_pulses: got %0d want 1", nm, pulses);
    end
    n_checks++;
    if (bus_cyc != e_bus) begin
      n_fail++; $display("FAIL %s bus_cycles: got %0d want %0d", nm, bus_cyc, e_bus);
    end
    n_checks++;
    if (!bus_ok) begin
      n_fail++;
      $display("FAIL %s bus_fields: last WE=%b ADR=%h SEL=%b DAT=%h want WE=%b ADR=%h SEL=%b DAT=%h",
               nm, WE_O, ADR_O, SEL_O, DAT_O, we, addr, e_sel, e_dat);
    end
    n_checks++;
    if (g_rd !== e_rd) begin
      n_fail++; $display("FAIL %s rdata: got %h want %h", nm, g_rd, e_rd);
    end
    n_checks++;
    if (g_mis !== mis) begin
      n_fail++; $display("FAIL %s misaligned: got %b want %b", nm, g_mis, mis);
    end
    n_checks++;
    if (g_to !== e_to) begin
      n_fail++; $display("FAIL %s timeout: got %b want %b", nm, g_to, e_to);
    end
    n_checks++;
    if (req_ready_o !== 1'b1 || resp_misaligned_o !== 1'b0 || resp_timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_resp: ready=%b mis=%b to=%b want 1 0 0", nm,
               req_ready_o, resp_misaligned_o, resp_timeout_o);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_reset;
    RST_I = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'd0;
    req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    repeat (3) @(negedge CLK_I);
    n_checks++;
    if ({CYC_O, STB_O, WE_O} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got CYC/STB/WE=%b%b%b want 000", CYC_O, STB_O, WE_O);
    end
    n_checks++;
    if ({resp_valid_o, resp_misaligned_o, resp_timeout_o} !== 3'b000 || resp_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_resp: got v=%b m=%b t=%b rdata=%h want 0", resp_valid_o,
                         resp_misaligned_o, resp_timeout_o, resp_rdata_o);
    end
    n_checks++;
    if (ADR_O !== 24'h0 || DAT_O !== 32'h0 || SEL_O !== 4'h0) begin
      n_fail++; $display("FAIL reset_bus: got ADR=%h DAT=%h SEL=%b want 0", ADR_O, DAT_O, SEL_O);
    end
    n_checks++;
    if (req_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready_o);
    end
    RST_I = 1'b0;
    #1;
    n_checks++;
    if (req_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b want 1", req_ready_o);
    end
    @(negedge CLK_I);
  endtask

  task automatic test_store;
    run_txn("sb_13", 1'b1, 2'd0, 1'b0, 24'h000013, 32'h000000A5, 32'h0, 0, 1'b1);
    run_txn("sh_02", 1'b1, 2'd1, 1'b0, 24'h000002, 32'hFFFF1234, 32'h0, 1, 1'b1);
    run_txn("sw_08", 1'b1, 2'd2, 1'b0, 24'h000008, 32'hCAFEF00D, 32'h0, 2, 1'b1);
  endtask

  task automatic test_load;
    run_txn("lb_13",  1'b0, 2'd0, 1'b0, 24'h000013, 32'h0, 32'h80123456, 0, 1'b1);
    run_txn("lbu_13", 1'b0, 2'd0, 1'b1, 24'h000013, 32'h0, 32'h80123456, 0, 1'b1);
    run_txn("lh_02",  1'b0, 2'd1, 1'b0, 24'h000002, 32'h0, 32'h80011234, 0, 1'b1);
    run_txn("lhu_00", 1'b0, 2'd1, 1'b1, 24'h000000, 32'h0, 32'h80019234, 1, 1'b1);
    run_txn("lw_04",  1'b0, 2'd2, 1'b0, 24'h000004, 32'h0, 32'h9ABCDEF0, 2, 1'b1);
  endtask

  task automatic test_misaligned;
    run_txn("lw_06",  1'b0, 2'd2, 1'b0, 24'h000006, 32'h0, 32'h11111111, 0, 1'b1);
    run_txn("sh_01",  1'b1, 2'd1, 1'b0, 24'h000001, 32'h5555, 32'h0, 0, 1'b1);
    run_txn("size11", 1'b0, 2'd3, 1'b0, 24'h000010, 32'h0, 32'h22222222, 0, 1'b1);
  endtask

  task automatic test_timeout;
    run_txn("lw_timeout", 1'b0, 2'd2, 1'b0, 24'h000020, 32'h0, 32'h76543210, 0, 1'b0);
    ack_force = 1'b1;
    @(negedge CLK_I);
    ack_force = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (resp_valid_o !== 1'b0 || CYC_O !== 1'b0 || req_ready_o !== 1'b1) begin
        n_fail++; $display("FAIL late_ack: got v=%b CYC=%b ready=%b want 0 0 1",
                           resp_valid_o, CYC_O, req_ready_o);
      end
      @(negedge CLK_I);
    end
    run_txn("sb_timeout", 1'b1, 2'd0, 1'b0, 24'h000031, 32'h3C, 32'h0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_bus;
    bit saw_resp = 1'b0;
    ack_en = 1'b0;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd2; req_unsigned_i = 1'b0;
    req_addr_i = 24'h000040; req_wdata_i = 32'hDEADBEEF;
    @(posedge CLK_I);
    #1 req_valid_i = 1'b0;
    @(negedge CLK_I);
    n_checks++;
    if (CYC_O !== 1'b1 || STB_O !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_setup: got CYC=%b STB=%b want 1 1", CYC_O, STB_O);
    end
    #2 RST_I = 1'b1;
    #1;
    n_checks++;
    if (CYC_O !== 1'b0 || STB_O !== 1'b0 || req_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_async: got CYC=%b STB=%b ready=%b want 0 0 0",
                         CYC_O, STB_O, req_ready_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK_I);
      if (resp_valid_o !== 1'b0) saw_resp = 1'b1;
    end
    RST_I = 1'b0;
    ack_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK_I);
      if (resp_valid_o !== 1'b0) saw_resp = 1'b1;
    end
    n_checks++;
    if (saw_resp) begin
      n_fail++; $display("FAIL rst_mid_no_resp: got resp_valid pulse want none");
    end
    run_txn("sw_after_rst", 1'b1, 2'd2, 1'b0, 24'h000100, 32'h12345678, 32'h0, 0, 1'b1);
  endtask

  task automatic test_back_to_back;
    run_txn("b2b_sw", 1'b1, 2'd2, 1'b0, 24'h000200, 32'h0F0F0F0F, 32'h0, 0, 1'b1);
    run_txn("b2b_lb", 1'b0, 2'd0, 1'b0, 24'h000201, 32'h0, 32'h0000FE00, 0, 1'b1);
    run_txn("b2b_sh", 1'b1, 2'd1, 1'b0, 24'h000203, 32'h00007777, 32'h0, 0, 1'b1);
    run_txn("b2b_lh", 1'b0, 2'd1, 1'b1, 24'h000202, 32'h0, 32'hF00D0000, 0, 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      run_txn("rand", 1'($urandom), 2'($urandom), 1'($urandom), 24'($urandom),
              $urandom, $urandom, int'($urandom_range(0, 2)), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_misaligned();
    test_timeout();
    test_reset_mid_bus();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_lsu_master.md
Name: wb_lsu_master

Overview:
- Wishbone classic single-transfer master (initiator) that sits between the CPU core's load/store stage and the shared Wishbone bus used by the RAM and other slaves.
- Accepts one byte/half/word load or store request at a time from the core.
- Drives CYC/STB/WE/ADR/DAT/SEL and waits for ACK.
- Performs read lane extraction and sign/zero extension, which slaves do not do; detects misalignment; enforces an ACK timeout.

Parameters:
ADDR_WIDTH, 24, byte-address width of ADR_O and req_addr_i
REGISTERED_READ, 1, 1: slave read data is valid the cycle after ACK_I; 0: DAT_I is valid in the ACK_I cycle
TIMEOUT_CYCLES, 16, bus cycles to wait for ACK_I before aborting; 0 disables the timeout

Ports:
CLK_I  input  1  clock, all logic on rising edge
RST_I  input  1  reset, asynchronous, active-high
req_valid_i  input  1  core request valid
req_ready_o  output  1  master idle, request accepted when valid&ready
req_we_i  input  1  1=store, 0=load
req_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned_i  input  1  loads: 1=zero-extend, 0=sign-extend
req_addr_i  input  ADDR_WIDTH  byte address
req_wdata_i  input  32  store data, right-aligned
resp_valid_o  output  1  one-cycle completion pulse
resp_rdata_o  output  32  extended load data (0 for stores and errors)
resp_misaligned_o  output  1  valid with resp_valid_o
resp_timeout_o  output  1  valid with resp_valid_o
CYC_O  output  1  bus cycle
STB_O  output  1  strobe
WE_O  output  1  write enable
ADR_O  output  ADDR_WIDTH  byte address, low bits unmodified
DAT_O  output  32  write data
SEL_O  output  4  byte selects
ACK_I  input  1  slave acknowledge (may be combinational from STB)
DAT_I  input  32  slave read data

Behaviour:
- Reset (async): state IDLE; CYC_O, STB_O, WE_O, resp_valid_o, resp_misaligned_o, resp_timeout_o = 0; ADR_O, DAT_O, SEL_O, resp_rdata_o = 0; timeout counter = 0. req_ready_o = 0 while RST_I is high.
- Reset mid-transaction: CYC_O/STB_O drop immediately. The request is discarded with no response.
- States: IDLE, BUS, CAPTURE, RESP. All bus outputs are registered.
- IDLE: req_ready_o = 1. On valid&ready, latch we, size, unsigned, addr, wdata.
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0; size 11. Goes to RESP with misaligned=1. No bus activity.
  - Otherwise goes to BUS, asserting CYC_O=STB_O=1 on the next edge.
- SEL_O:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
  - SEL_O is also driven for loads.
- DAT_O: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- BUS: CYC/STB/WE/ADR/DAT/SEL are held stable until ACK_I.
  - On the ACK_I edge, CYC_O/STB_O deassert on that same edge.
  - Store: go to RESP.
  - Load, REGISTERED_READ=0: sample DAT_I on the ACK edge, go to RESP.
  - Load, REGISTERED_READ=1: go to CAPTURE.
- CAPTURE: one cycle with CYC/STB low. Sample DAT_I at its end, go to RESP.
- Load extraction:
  - byte lane DAT_I[8*a+7:8*a], where a = addr[1:0]
  - half lane DAT_I[16*addr[1]+15:16*addr[1]]
  - Extend per req_unsigned_i; word is passed through.
- Timeout: counter increments each BUS cycle without ACK_I. When it reaches TIMEOUT_CYCLES:
  - deassert CYC/STB, go to RESP with timeout=1 and rdata=0;
  - a late ACK_I is ignored.
  - The counter clears on entering BUS.
- RESP: resp_valid_o=1 for exactly one cycle, then IDLE. resp_* flags are cleared on leaving RESP.
- Latency (accept at cycle 0, zero-wait slave):
  - STB high in cycle 1
  - store resp_valid in cycle 2
  - load resp_valid in cycle 2 (REGISTERED_READ=0) or cycle 3 (REGISTERED_READ=1)
  - misaligned resp_valid in cycle 1
- Requests are never accepted outside IDLE; back-to-back requests are accepted the cycle after RESP.

Test Plan:
- SB addr 0x000013, wdata 0x000000A5 -> one cycle with SEL_O=1000, DAT_O=0xA5A5A5A5, WE_O=1, ADR_O=0x000013; resp_valid in cycle 2, flags 0.
- LB / LBU addr 0x000013 (REGISTERED_READ=1), DAT_I=0x80123456 in the cycle after ACK -> rdata 0xFFFFFF80 (LB), 0x00000080 (LBU); resp_valid in cycle 3.
- LH addr 0x000002, DAT_I=0x80011234 -> SEL_O=1100, rdata 0xFFFF8001. LW addr 0x000004 -> rdata equals DAT_I.
- LW addr 0x000006 and SH addr 0x000001 -> resp_misaligned_o=1 in cycle 1; CYC_O never asserted.
- TIMEOUT_CYCLES=4, ACK_I held low -> STB_O high exactly 4 cycles, then resp_timeout_o=1, rdata 0; a later ACK_I pulse has no effect.
- Assert RST_I while in BUS -> CYC_O/STB_O low without waiting for a clock edge, no resp_valid; after release, req_ready_o=1 and a new SW completes normally.
